// File: rtl/calc_key_conditioner.sv
// Key conditioner ahead of the calculator FSM: synchronise, debounce,
// encode, and emit one clean event per physical press.
module calc_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] switch,
  input  logic       op_add,
  input  logic       op_sub,
  output logic       digit_valid,
  output logic [3:0] digit,
  output logic       add_pulse,
  output logic       sub_pulse,
  output logic       multi_key_err,
  output logic       key_busy
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [11:0]   raw;
  logic [11:0]   meta_q;
  logic [11:0]   sync_q;
  logic [11:0]   cand_q;
  logic [11:0]   stable_q;
  logic [CW-1:0] cnt_q;

  state_t        state_q;
  logic [11:0]   key_q;
  logic          one_hot;
  logic          multi;
  logic [3:0]    enc;

  assign raw = {op_sub, op_add, switch};

  // The whole vector must hold still before any of it is believed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      if (sync_q != cand_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        stable_q <= cand_q;
      end
    end
  end

  assign one_hot = (stable_q != '0) &&
                   ((stable_q & (stable_q - 12'd1)) == '0);
  assign multi   = (stable_q != '0) && !one_hot;

  always_comb begin
    enc = '0;
    for (int i = 0; i < 10; i++) begin
      if (stable_q[i]) enc = 4'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      key_q         <= '0;
      digit_valid   <= 1'b0;
      digit         <= '0;
      add_pulse     <= 1'b0;
      sub_pulse     <= 1'b0;
      multi_key_err <= 1'b0;
      key_busy      <= 1'b0;
    end else begin
      digit_valid   <= 1'b0;
      add_pulse     <= 1'b0;
      sub_pulse     <= 1'b0;
      multi_key_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (one_hot) begin
            state_q  <= PRESSED;
            key_q    <= stable_q;
            key_busy <= 1'b1;
            unique case (1'b1)
              stable_q[11]: sub_pulse <= 1'b1;
              stable_q[10]: add_pulse <= 1'b1;
              default: begin
                digit_valid <= 1'b1;
                digit       <= enc;
              end
            endcase
          end else if (multi) begin
            state_q       <= WAIT_RELEASE;
            multi_key_err <= 1'b1;
            key_busy      <= 1'b1;
          end
        end
        PRESSED: begin
          if (stable_q == '0) begin
            state_q  <= IDLE;
            key_busy <= 1'b0;
          end else if ((stable_q & ~key_q) != '0) begin
            state_q <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (stable_q == '0) begin
            state_q  <= IDLE;
            key_busy <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          key_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/calc_key_conditioner.md
Name: calc_key_conditioner

Overview:
Input-conditioning stage directly upstream of the digital calculator FSM. Synchronises and debounces the ten number switches and the add/sub buttons. Encodes the one-hot switch bank into a 4-bit digit. Emits exactly one single-cycle event per physical press, so the calculator FSM never sees bounce, held levels or illegal multi-key combinations.

Parameters:
DEBOUNCE_CYCLES, 4, clocks a synchronised input vector must stay unchanged before it is accepted; legal range 1..255; counter width derived internally via $clog2

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
switch  input  10  raw number switches, bit n = digit n, asynchronous to clock
op_add  input  1  raw add button, asynchronous
op_sub  input  1  raw subtract button, asynchronous
digit_valid  output  1  one-cycle pulse: a single number switch was pressed
digit  output  4  encoded digit 0..9, valid when digit_valid=1, holds last value otherwise
add_pulse  output  1  one-cycle pulse: add button pressed alone
sub_pulse  output  1  one-cycle pulse: sub button pressed alone
multi_key_err  output  1  one-cycle pulse: more than one key became active together
key_busy  output  1  high while a key press is in progress (FSM not in IDLE)

Behaviour:
- Reset (async assert, released on the next edge): sync flops, candidate, stable vector and counter = 0; FSM = IDLE; all outputs 0, digit = 0.
- Raw 12-bit vector raw = {op_sub, op_add, switch}; two-flop synchroniser per bit gives sync.
- Debounce, whole vector: if sync != cand then cand <= sync and cnt <= 0. Otherwise cnt increments, saturating at DEBOUNCE_CYCLES-1. When cnt == DEBOUNCE_CYCLES-1 and sync == cand, stable <= cand.
- Any change lasting fewer than DEBOUNCE_CYCLES+1 synchronised cycles never reaches stable.
- FSM states:
  - IDLE: stable == 0. On exactly one bit set: emit the matching pulse, go PRESSED. On more than one bit set: pulse multi_key_err, go WAIT_RELEASE.
  - PRESSED: no further pulses. Any extra bit becoming set goes to WAIT_RELEASE with no error pulse. stable == 0 returns to IDLE.
  - WAIT_RELEASE: ignore everything until stable == 0, then IDLE.
- Outputs are registered. The event pulse is high for exactly one cycle, first visible after rising edge DEBOUNCE_CYCLES+4, counted from the first edge that samples the new raw value. Default latency = 8 clocks.
- digit: index of the single set switch bit. Loaded in the same cycle digit_valid asserts.
- Digit switch plus op button together counts as multi-key: multi_key_err only, no digit or op pulse.
- Holding a key indefinitely produces one pulse. Release is debounced identically, so the next press needs a debounced return to zero first.
- Reset mid-press: everything clears. A key still held after reset release is debounced again and yields a fresh pulse after DEBOUNCE_CYCLES+4 edges.
- key_busy = 1 in PRESSED and WAIT_RELEASE, 0 in IDLE.
- At most one of digit_valid, add_pulse, sub_pulse, multi_key_err is high in any cycle.

Test Plan:
- Reset, set switch[3]=1 held 20 clocks -> digit_valid high exactly one cycle at edge 8 after change, digit=3, key_busy=1. Release -> key_busy=0 after 8 more edges.
- switch[5]=1 for 2 clocks only (glitch), DEBOUNCE_CYCLES=4 -> no pulse of any kind, key_busy stays 0.
- Sequence: switch[3], release, op_add, release, switch[8], release, each held 12 clocks -> pulses in order digit_valid(3), add_pulse, digit_valid(8); no sub_pulse.
- switch[2] and switch[7] rising on the same edge -> single multi_key_err pulse, no digit_valid. Next clean switch[4] press after full release -> digit_valid, digit=4.
- switch[9] held, press op_sub 15 clocks later while still holding -> one digit_valid(9) only, no sub_pulse, no multi_key_err, key_busy stays 1 until both released.
- op_sub held, reset asserted for 3 clocks mid-press, then released with op_sub still held -> all outputs 0 during reset, then exactly one sub_pulse 8 edges after reset release.
